sysid_checker: RTL

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker.sv | 118 +++++++++++
 1 files changed

// File: rtl/sysid_checker.sv
// Reads the system ID slave (ID at word 0, timestamp at word 1) and compares both words against expected values.
// Optional periodic self-recheck while DONE is enabled by defining SYSID_CHECKER_RECHECK_EN.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h5530_FA57,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RECHECK_PERIOD = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  state_t     state, state_nx;
  logic [3:0] wait_cnt;
  logic       hit;
  logic       self_start;

`ifdef SYSID_CHECKER_RECHECK_EN
  logic [15:0] rc_cnt;

  // Counts cycles spent in DONE; any exit from DONE clears it.
  always_ff @(posedge clock) begin
    if (reset)                                rc_cnt <= '0;
    else if (state == DONE && state_nx == DONE) rc_cnt <= rc_cnt + 16'd1;
    else                                      rc_cnt <= '0;
  end

  assign self_start = (state == DONE) && (rc_cnt == 16'(RECHECK_PERIOD - 1));
`else
  wire unused_recheck = |RECHECK_PERIOD;
  assign self_start = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    busy          = 1'b0;
    sysid_read    = 1'b0;
    sysid_address = 1'b0;
    hit           = (wait_cnt == LAT);
    unique case (state)
      IDLE: if (start) state_nx = RD_ID;
      RD_ID: begin
        busy       = 1'b1;
        sysid_read = 1'b1;
        if (hit) state_nx = RD_TS;
      end
      RD_TS: begin
        busy          = 1'b1;
        sysid_read    = 1'b1;
        sysid_address = 1'b1;
        if (hit) state_nx = DONE;
      end
      DONE: if (start || self_start) state_nx = RD_ID;
    endcase
  end

  // Results hold in DONE; they are cleared only when a new check is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      done     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (state_nx == RD_ID) begin
            wait_cnt <= '0;
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
          end
        end
        RD_ID: begin
          if (hit) begin
            id_value <= sysid_readdata;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RD_TS: begin
          if (hit) begin
            ts_value <= sysid_readdata;
            wait_cnt <= '0;
            done     <= 1'b1;
            id_ok    <= (id_value == EXPECTED_ID);
            ts_ok    <= (sysid_readdata == EXPECTED_TS);
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule
